// File: rtl/disp_pkg.sv
// Shared definitions for the alarm-clock digit display controller.
// Holds the set-mode FSM state encoding, digit field types, digit maxima
// and the bit positions of the per-digit blank vector.
package disp_pkg;

    localparam int MT_W = 3;   // minutes/seconds tens digit width
    localparam int MO_W = 4;   // minutes/seconds ones digit width

    typedef logic [MT_W-1:0] tens_t;
    typedef logic [MO_W-1:0] ones_t;

    localparam tens_t MT_MAX = 3'd5;
    localparam ones_t MO_MAX = 4'd9;

    localparam logic [1:0] ST_TIME     = 2'd0;
    localparam logic [1:0] ST_SET_TENS = 2'd1;
    localparam logic [1:0] ST_SET_ONES = 2'd2;
    localparam logic [1:0] ST_RING     = 2'd3;

    localparam int BLK_MT = 3;
    localparam int BLK_MO = 2;
    localparam int BLK_ST = 1;
    localparam int BLK_SO = 0;

endpackage

// File: rtl/digit_display_ctrl_if.sv
// Bus between the display controller and its surroundings.
// Inputs to the controller: frame_start, btn_mode, btn_inc, alarm_hit and
// the live time digits. Outputs: renderer digits, digit_blank, colon_on,
// stored alarm minutes and ring_active.
// master = environment side, slave = controller side.
interface digit_display_ctrl_if;
    import disp_pkg::*;

    logic       frame_start;
    logic       btn_mode;
    logic       btn_inc;
    logic       alarm_hit;
    tens_t      time_mt;
    ones_t      time_mo;
    tens_t      time_st;
    ones_t      time_so;
    tens_t      minutes_tens;
    ones_t      minutes_ones;
    tens_t      seconds_tens;
    ones_t      seconds_ones;
    logic [3:0] digit_blank;
    logic       colon_on;
    tens_t      alarm_mt;
    ones_t      alarm_mo;
    logic       ring_active;

    modport master (
        output frame_start, btn_mode, btn_inc, alarm_hit,
        output time_mt, time_mo, time_st, time_so,
        input  minutes_tens, minutes_ones, seconds_tens, seconds_ones,
        input  digit_blank, colon_on, alarm_mt, alarm_mo, ring_active
    );

    modport slave (
        input  frame_start, btn_mode, btn_inc, alarm_hit,
        input  time_mt, time_mo, time_st, time_so,
        output minutes_tens, minutes_ones, seconds_tens, seconds_ones,
        output digit_blank, colon_on, alarm_mt, alarm_mo, ring_active
    );

endinterface

// File: rtl/frame_blink_gen.sv
// Frame-counting blink generator.
// Ports: clk, rst (sync, active-high), frame_start (vblank pulse),
// restart (force counter to 0 and phase visible), blink_phase (1 = visible).
// blink_phase toggles every BLINK_FRAMES frame_start pulses.
module frame_blink_gen #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic restart,
    output logic blink_phase
);

    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (cnt == CW'(BLINK_FRAMES - 1)) begin
                cnt         <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_display_ctrl.sv
// Alarm-clock display controller for the VGA digit path.
// Ports: clk, rst (sync, active-high) and bus (digit_display_ctrl_if.slave)
// carrying frame_start/button/alarm pulses, live time digits in, and the
// renderer digits, digit_blank, colon_on, alarm minutes, ring_active out.
// Renderer outputs load only on frame_start so a frame never tears.
// Build option: define AUTO_EXIT_EN to leave set mode after TIMEOUT_FRAMES
// idle frames.
module digit_display_ctrl
    import disp_pkg::*;
#(
    parameter int BLINK_FRAMES   = 30,
    parameter int TIMEOUT_FRAMES = 600,
    parameter int RING_FRAMES    = 1800
) (
    input  logic clk,
    input  logic rst,
    digit_display_ctrl_if.slave bus
);

    localparam int RW = $clog2(RING_FRAMES + 1);

    logic [1:0]    state, state_next;
    tens_t         alarm_mt;
    ones_t         alarm_mo;
    logic [RW-1:0] ring_cnt;
    logic          blink_phase;
    logic          blink_restart;
    logic          any_btn;
    logic          ring_done;
    logic          in_set;
    logic          timeout_hit;

    tens_t         nxt_mt, nxt_st;
    ones_t         nxt_mo, nxt_so;
    logic [3:0]    nxt_blank;
    logic          nxt_colon;

    function automatic tens_t inc_tens(input tens_t v);
        return (v == MT_MAX) ? '0 : v + 3'd1;
    endfunction

    function automatic ones_t inc_ones(input ones_t v);
        return (v == MO_MAX) ? '0 : v + 4'd1;
    endfunction

    assign any_btn   = bus.btn_mode | bus.btn_inc;
    assign in_set    = (state == ST_SET_TENS) || (state == ST_SET_ONES);
    assign ring_done = (state == ST_RING) && bus.frame_start
                       && (ring_cnt == RW'(RING_FRAMES - 1));

`ifdef AUTO_EXIT_EN
    localparam int IW = $clog2(TIMEOUT_FRAMES + 1);
    logic [IW-1:0] idle_cnt;

    assign timeout_hit = in_set && bus.frame_start
                         && (idle_cnt == IW'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (rst || any_btn || (state_next != state)) begin
            idle_cnt <= '0;
        end else if (in_set && bus.frame_start) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // No auto-exit in this build; TIMEOUT_FRAMES is kept so both builds
    // share one parameter list.
    assign timeout_hit = 1'b0 && (TIMEOUT_FRAMES != 0);
`endif

    // Priority: alarm_hit > btn_mode > btn_inc > timeouts.
    always_comb begin
        state_next = state;
        if (bus.alarm_hit) begin
            state_next = ST_RING;
        end else if (state == ST_RING) begin
            if (any_btn || ring_done) state_next = ST_TIME;
        end else if (bus.btn_mode) begin
            case (state)
                ST_TIME:     state_next = ST_SET_TENS;
                ST_SET_TENS: state_next = ST_SET_ONES;
                default:     state_next = ST_TIME;
            endcase
        end else if (!bus.btn_inc && timeout_hit) begin
            state_next = ST_TIME;
        end
    end

    // Entering an edit field shows it immediately, whatever the blink phase.
    assign blink_restart = ((state_next == ST_SET_TENS) || (state_next == ST_SET_ONES))
                           && (state_next != state);

    frame_blink_gen #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .rst         (rst),
        .frame_start (bus.frame_start),
        .restart     (blink_restart),
        .blink_phase (blink_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_TIME;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.alarm_hit) begin
            ring_cnt <= '0;
        end else if ((state == ST_RING) && bus.frame_start) begin
            ring_cnt <= ring_cnt + 1'b1;
        end
    end

    // btn_inc only edits when neither a higher-priority event nor a mode
    // press is present in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_mt <= '0;
            alarm_mo <= '0;
        end else if (!bus.alarm_hit && !bus.btn_mode && bus.btn_inc) begin
            if (state == ST_SET_TENS) alarm_mt <= inc_tens(alarm_mt);
            if (state == ST_SET_ONES) alarm_mo <= inc_ones(alarm_mo);
        end
    end

    always_comb begin
        nxt_mt    = bus.time_mt;
        nxt_mo    = bus.time_mo;
        nxt_st    = bus.time_st;
        nxt_so    = bus.time_so;
        nxt_blank = 4'b0000;
        nxt_colon = blink_phase;
        case (state)
            ST_SET_TENS, ST_SET_ONES: begin
                nxt_mt            = alarm_mt;
                nxt_mo            = alarm_mo;
                nxt_st            = '0;
                nxt_so            = '0;
                nxt_colon         = 1'b1;
                nxt_blank[BLK_ST] = 1'b1;
                nxt_blank[BLK_SO] = 1'b1;
                if (state == ST_SET_TENS) nxt_blank[BLK_MT] = ~blink_phase;
                else                      nxt_blank[BLK_MO] = ~blink_phase;
            end
            ST_RING: nxt_blank = {4{~blink_phase}};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.minutes_tens <= '0;
            bus.minutes_ones <= '0;
            bus.seconds_tens <= '0;
            bus.seconds_ones <= '0;
            bus.digit_blank  <= 4'b0000;
            bus.colon_on     <= 1'b1;
        end else if (bus.frame_start) begin
            bus.minutes_tens <= nxt_mt;
            bus.minutes_ones <= nxt_mo;
            bus.seconds_tens <= nxt_st;
            bus.seconds_ones <= nxt_so;
            bus.digit_blank  <= nxt_blank;
            bus.colon_on     <= nxt_colon;
        end
    end

    assign bus.alarm_mt    = alarm_mt;
    assign bus.alarm_mo    = alarm_mo;
    assign bus.ring_active = (state == ST_RING);

endmodule

// File: doc/digit_display_ctrl.md
Name: digit_display_ctrl

Overview:
- Display controller for the alarm-clock VGA digit path.
- Decides which digits the character renderer shows: live time, alarm-set view or ringing view.
- Owns the alarm-minute register and sequences the set-mode FSM.
- Produces blink and colon control, and updates all display outputs only on frame boundaries, so there is no mid-frame tearing.

Parameters:
- BLINK_FRAMES, 30, frames per blink half-period (0.5 s at 60 Hz).
- TIMEOUT_FRAMES, 600, idle frames before set mode auto-exits (AUTO_EXIT_EN only).
- RING_FRAMES, 1800, frames the ring view lasts without a button press.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- btn_mode  in  1  debounced one-cycle press pulse.
- btn_inc  in  1  debounced one-cycle press pulse.
- alarm_hit  in  1  one-cycle pulse from the alarm comparator.
- time_mt  in  3  live minutes tens.
- time_mo  in  4  live minutes ones.
- time_st  in  3  live seconds tens.
- time_so  in  4  live seconds ones.
- minutes_tens  out  3  digit to renderer.
- minutes_ones  out  4  digit to renderer.
- seconds_tens  out  3  digit to renderer.
- seconds_ones  out  4  digit to renderer.
- digit_blank  out  4  per-digit blank, bit3=minutes_tens … bit0=seconds_ones.
- colon_on  out  1  colon visible.
- alarm_mt  out  3  stored alarm minutes tens.
- alarm_mo  out  4  stored alarm minutes ones.
- ring_active  out  1  high while in RING.

Behaviour:
- Reset values:
  - Display digit outputs, alarm_mt and alarm_mo are 0.
  - digit_blank is 4'b0000, colon_on is 1, ring_active is 0.
  - State is TIME; blink counter is 0 and blink_phase is 1 (visible).
- States: TIME, SET_TENS, SET_ONES, RING.
- Transitions, evaluated every clk; priority is alarm_hit > btn_mode > btn_inc > timeouts:
  - Any state with alarm_hit: go to RING and clear ring_cnt. In RING this restarts the ring.
  - TIME with btn_mode: go to SET_TENS.
  - SET_TENS with btn_mode: go to SET_ONES.
  - SET_ONES with btn_mode: go to TIME.
  - SET_TENS with btn_inc: alarm_mt = (alarm_mt==5) ? 0 : alarm_mt+1.
  - SET_ONES with btn_inc: alarm_mo = (alarm_mo==9) ? 0 : alarm_mo+1.
  - btn_mode and btn_inc in the same cycle: mode wins and inc is dropped.
  - RING with any button: go to TIME. The press is consumed and has no other effect.
  - RING when ring_cnt reaches RING_FRAMES-1 on a frame_start: go to TIME.
- Alarm register updates take effect the cycle after the press.
- Blink generator:
  - Counts frame_start pulses from 0 to BLINK_FRAMES-1; at wrap it returns to 0 and toggles blink_phase.
  - Entering SET_TENS or SET_ONES forces counter=0 and phase=1, so the edited field appears immediately.
- Display outputs are registered and load only in a cycle where frame_start=1, from that cycle's state and inputs. They are visible the next cycle and held stable between frames.
- Output contents per state:
  - TIME: live digits; blank=0000; colon_on=blink_phase.
  - SET_TENS: minutes show alarm_mt:alarm_mo; seconds digits 0 and blanked (bits1:0=11); bit3=~blink_phase; colon_on=1.
  - SET_ONES: same as SET_TENS except bit2=~blink_phase and bit3=0.
  - RING: live digits; all four blank bits=~blink_phase; colon_on=blink_phase.
- ring_active is combinational from state, not frame-latched.
- rst asserted mid-operation returns everything to reset values on the next edge. Alarm setting is lost.

Optional Feature:
- Macro: AUTO_EXIT_EN.
- Defined: an idle counter clears on any button or state change and increments on frame_start while in SET_TENS or SET_ONES. At TIMEOUT_FRAMES-1 plus frame_start it returns to TIME, keeping alarm values already entered.
- Undefined: no idle counter. Set states persist until btn_mode or alarm_hit.

Decomposition:
- Shared package (disp_pkg):
  - state encoding.
  - digit widths (3/4).
  - digit maxima (5, 9).
  - blank-bit index constants.
- Sub-module frame_blink_gen: frame counter and blink_phase, with restart input and BLINK_FRAMES parameter.

Test Plan:
- Reset, then 3 frames, with time=12:34 → outputs 1,2,3,4; blank=0000; colon toggles every 30 frames.
- btn_mode, then btn_inc ×7 in SET_TENS → alarm_mt 0→5→0→1 (wraps at 5); digit_blank[3] on for 30 frames, off for 30, starting visible.
- SET_ONES with btn_inc ×12 → alarm_mo=2; btn_mode → TIME. Mid-frame time change appears only after the next frame_start.
- alarm_hit and btn_mode in the same cycle from TIME → RING, ring_active=1 next cycle. Any press → TIME. With no press, return to TIME after 1800 frames.
- btn_mode and btn_inc together in SET_TENS → SET_ONES, alarm_mt unchanged.
- AUTO_EXIT_EN defined: enter SET_TENS, idle 600 frames → TIME. Undefined: still SET_TENS after 700 frames.
